imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader_word_pack.sv | 50 +++++
 rtl/imem_loader.sv | 112 +++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package loader_pkg;

   localparam int LEN_W  = 16;
   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;

   localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

   // Frame parser states; DONE/ERROR are sticky until start.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEN_HI  = 3'd1,
      LEN_LO  = 3'd2,
      DATA_HI = 3'd3,
      DATA_LO = 3'd4,
      CHECK   = 3'd5,
      DONE    = 3'd6,
      ERROR   = 3'd7
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in / instruction memory write port out, as seen by the loader.
interface imem_loader_if;
   import loader_pkg::*;

   logic [BYTE_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [15:0]       mem_addr;
   logic [WORD_W-1:0] mem_wdata;

   // Byte source and memory side.
   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   // Loader side.
   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/imem_loader_word_pack.sv
// Pairs hi/lo bytes into 16-bit words and issues one registered memory write per word.
module loader_word_pack
   import loader_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              hi_load,
   input  logic              lo_load,
   input  logic [BYTE_W-1:0] byte_in,
   output logic              mem_we,
   output logic [15:0]       mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic [LEN_W-1:0]  words_loaded
);

   logic [BYTE_W-1:0] hi_q;
   logic              we_q;

   // Hold the high byte until its low partner arrives.
   always_ff @(posedge clk) begin
      if (reset)        hi_q <= '0;
      else if (hi_load) hi_q <= byte_in;
   end

   // Write strobe, address and data land one cycle after the low byte; count advances with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q         <= 1'b0;
         mem_addr     <= BASE_ADDR;
         mem_wdata    <= '0;
         words_loaded <= '0;
      end else begin
         we_q <= lo_load;
         if (lo_load) begin
            mem_addr     <= BASE_ADDR + {words_loaded[14:0], 1'b0};
            mem_wdata    <= {hi_q, byte_in};
            words_loaded <= words_loaded + 16'd1;
         end else if (clear) begin
            words_loaded <= '0;
         end
      end
   end

   // A write queued just before reset must not reach memory while reset is held.
   assign mem_we = we_q & ~reset;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the CPU until a good frame lands.
module imem_loader
   import loader_pkg::*;
#(
   parameter logic [15:0]       BASE_ADDR = 16'h0000,
   parameter int                MAX_WORDS = 256,
   parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   imem_loader_if.slave     bus,
   output logic             cpu_hold,
   output logic             done,
   output logic             error,
   output logic [LEN_W-1:0] words_loaded
);

   // Highest written address must stay below the 16-bit wrap point.
   if (int'(BASE_ADDR) + 2 * (MAX_WORDS - 1) > 32'h0000_FFFE) begin : g_range_chk
      $error("imem_loader: BASE_ADDR + 2*(MAX_WORDS-1) exceeds 16'hFFFE");
   end

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [BYTE_W-1:0] sum_q, sum_d;
   logic              accept;
   logic              hi_load, lo_load, clear;

   assign bus.in_ready = (state_q != DONE) && (state_q != ERROR);
   assign accept       = bus.in_valid && bus.in_ready;

   assign done     = (state_q == DONE);
   assign error    = (state_q == ERROR);
   assign cpu_hold = (state_q != DONE);

   // State, length and running checksum registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
      end
   end

   // Frame parser: advances only on accepted bytes, except the start re-arm.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      sum_d   = sum_q;
      hi_load = 1'b0;
      lo_load = 1'b0;
      clear   = 1'b0;
      case (state_q)
         IDLE: begin
            sum_d = '0;
            if (accept && bus.in_data == SYNC_BYTE) state_d = LEN_HI;
         end
         LEN_HI: if (accept) begin
            len_d   = {bus.in_data, len_q[7:0]};
            sum_d   = sum_q + bus.in_data;
            state_d = LEN_LO;
         end
         LEN_LO: if (accept) begin
            len_d = {len_q[15:8], bus.in_data};
            sum_d = sum_q + bus.in_data;
            if (len_d == '0)                   state_d = CHECK;
            else if (int'(len_d) > MAX_WORDS)  state_d = ERROR;
            else                               state_d = DATA_HI;
         end
         DATA_HI: if (accept) begin
            hi_load = 1'b1;
            sum_d   = sum_q + bus.in_data;
            state_d = DATA_LO;
         end
         DATA_LO: if (accept) begin
            lo_load = 1'b1;
            sum_d   = sum_q + bus.in_data;
            if (words_loaded + 16'd1 == len_q) state_d = CHECK;
            else                               state_d = DATA_HI;
         end
         CHECK: if (accept) begin
            state_d = (bus.in_data == sum_q) ? DONE : ERROR;
         end
         DONE, ERROR: if (start) begin
            clear   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   loader_word_pack #(
      .BASE_ADDR (BASE_ADDR)
   ) u_pack (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .hi_load      (hi_load),
      .lo_load      (lo_load),
      .byte_in      (bus.in_data),
      .mem_we       (bus.mem_we),
      .mem_addr     (bus.mem_addr),
      .mem_wdata    (bus.mem_wdata),
      .words_loaded (words_loaded)
   );

endmodule
